// File: rtl/seq_alu.sv
// Sequential ALU: one operation per request; SHR shifts one bit per cycle.
// Latency: 1 cycle for all ops except SHR with shamt=k>0, which takes k+1 cycles.
// Backpressure: in_ready only while idle; the result is held in DONE until out_ready.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [2:0]       mask,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             z_out,
  output logic             n_out,
  output logic             c_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_EXCH = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_SET  = 4'b1101;
  localparam logic [3:0] OP_CLR  = 4'b1110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  // single-cycle ALU result, computed straight from the request inputs
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] arith;
  logic             upd_zn;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_z;
  logic             alu_n;
  logic             alu_c;

  logic             accept;
  logic             shr_multi;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign z_out     = z_q;
  assign n_out     = n_q;
  assign c_out     = c_q;

  assign accept    = in_valid & in_ready;
  // SHR with a zero count behaves like a pass-through and finishes in one cycle
  assign shr_multi = (opcode == OP_SHR) && (shamt != '0);

  // combinational ALU for every opcode that completes in a single cycle
  always_comb begin
    alu_a   = a_in;
    alu_b   = b_in;
    alu_z   = z_in;
    alu_n   = n_in;
    alu_c   = c_in;
    arith   = '0;
    upd_zn  = 1'b0;
    sum_ext = {1'b0, a_in} + {1'b0, b_in};
    dif_ext = {1'b0, a_in} - {1'b0, b_in};
    case (opcode)
      OP_ADD: begin
        arith  = sum_ext[WIDTH-1:0];
        alu_a  = arith;
        alu_c  = sum_ext[WIDTH];
        upd_zn = 1'b1;
      end
      OP_SUB: begin
        arith  = dif_ext[WIDTH-1:0];
        alu_a  = arith;
        alu_c  = dif_ext[WIDTH];   // borrow: set when a_in < b_in
        upd_zn = 1'b1;
      end
      OP_CMP: begin
        arith  = dif_ext[WIDTH-1:0];  // difference only feeds the flags
        alu_c  = dif_ext[WIDTH];
        upd_zn = 1'b1;
      end
      OP_OR: begin
        arith  = a_in | b_in;
        alu_a  = arith;
        upd_zn = 1'b1;
      end
      OP_AND: begin
        arith  = a_in & b_in;
        alu_a  = arith;
        upd_zn = 1'b1;
      end
      OP_XOR: begin
        arith  = a_in ^ b_in;
        alu_a  = arith;
        upd_zn = 1'b1;
      end
      OP_MOV: begin
        alu_b = a_in;
      end
      OP_EXCH: begin
        alu_a = b_in;
        alu_b = a_in;
      end
      OP_SET: begin
        alu_z = z_in | mask[2];
        alu_n = n_in | mask[1];
        alu_c = c_in | mask[0];
      end
      OP_CLR: begin
        alu_z = z_in & ~mask[2];
        alu_n = n_in & ~mask[1];
        alu_c = c_in & ~mask[0];
      end
      default: begin
        // PASS, and SHR by zero: defaults already mirror the inputs
      end
    endcase
    if (upd_zn) begin
      alu_z = (arith == '0);
      alu_n = arith[WIDTH-1];
    end
  end

  // next-state and datapath update for the IDLE/SHIFT/DONE sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (shr_multi) begin
            // capture operands; the shifter works on the held copy from here on
            state_d = SHIFT;
            a_d     = a_in;
            b_d     = b_in;
            z_d     = z_in;
            n_d     = n_in;
            c_d     = c_in;
            cnt_d   = shamt;
          end else begin
            state_d = DONE;
            a_d     = alu_a;
            b_d     = alu_b;
            z_d     = alu_z;
            n_d     = alu_n;
            c_d     = alu_c;
          end
        end
      end
      SHIFT: begin
        // one logical right shift per cycle; carry keeps the bit last shifted out
        a_d   = a_q >> 1;
        c_d   = a_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register; reset wins over any accept or handshake on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random operations
// on a 16-bit instance, and a few 32-bit operations on a second instance,
// all compared with an arithmetic reference model.
module tb_seq_alu;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        z;
    logic        n;
    logic        c;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  opcode;
  logic [2:0]  mask;
  logic [3:0]  shamt;
  logic [15:0] a_in, b_in, a_out, b_out;
  logic        z_in, n_in, c_in, z_out, n_out, c_out;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [3:0]  w_opcode;
  logic [2:0]  w_mask;
  logic [4:0]  w_shamt;
  logic [31:0] w_a_in, w_b_in, w_a_out, w_b_out;
  logic        w_z_in, w_n_in, w_c_in, w_z_out, w_n_out, w_c_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .mask(mask), .shamt(shamt),
    .a_in(a_in), .b_in(b_in),
    .z_in(z_in), .n_in(n_in), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out),
    .z_out(z_out), .n_out(n_out), .c_out(c_out)
  );

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opcode(w_opcode), .mask(w_mask), .shamt(w_shamt),
    .a_in(w_a_in), .b_in(w_b_in),
    .z_in(w_z_in), .n_in(w_n_in), .c_in(w_c_in),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .a_out(w_a_out), .b_out(w_b_out),
    .z_out(w_z_out), .n_out(w_n_out), .c_out(w_c_out)
  );

  // reference behaviour written from the operation definitions with plain arithmetic
  function automatic res_t model(input int w, input logic [3:0] op, input logic [2:0] m,
                                 input int k, input logic [63:0] a, input logic [63:0] b,
                                 input logic z, input logic n, input logic c);
    res_t        r;
    logic [64:0] full;
    logic [63:0] msk;
    logic [63:0] v;
    bit          arith;
    msk   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r.a   = a; r.b = b; r.z = z; r.n = n; r.c = c;
    v     = '0;
    arith = 1'b0;
    full  = '0;
    case (op)
      4'h4: begin full = {1'b0, a} + {1'b0, b}; v = full[63:0] & msk; r.c = full[w]; arith = 1; r.a = v; end
      4'h5: begin v = (a - b) & msk; r.c = (a < b); arith = 1; r.a = v; end
      4'hC: begin v = (a - b) & msk; r.c = (a < b); arith = 1; end
      4'h6: begin v = a | b; arith = 1; r.a = v; end
      4'h7: begin v = a & b; arith = 1; r.a = v; end
      4'h8: begin v = a ^ b; arith = 1; r.a = v; end
      4'h9: begin r.a = a >> k; if (k > 0) r.c = a[k-1]; end
      4'hA: r.b = a;
      4'hB: begin r.a = b; r.b = a; end
      4'hD: begin r.z = z | m[2]; r.n = n | m[1]; r.c = c | m[0]; end
      4'hE: begin r.z = z & ~m[2]; r.n = n & ~m[1]; r.c = c & ~m[0]; end
      default: ;
    endcase
    if (arith) begin
      r.z = (v == 64'd0);
      r.n = v[w-1];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_ready16();
    int t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    chk("ready_before_req", {63'd0, in_ready}, 64'd1);
  endtask

  // one full request/response on the 16-bit instance; called at a negedge
  task automatic run16(input logic [3:0] op, input logic [2:0] m, input logic [3:0] k,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic z, input logic n, input logic c, input int stall);
    res_t e;
    int   lat;
    int   exp_lat;
    bit   rdy_bad;
    e       = model(16, op, m, int'(k), {48'd0, a}, {48'd0, b}, z, n, c);
    exp_lat = (op == 4'h9 && k != 4'd0) ? int'(k) + 1 : 1;
    wait_ready16();
    opcode = op; mask = m; shamt = k; a_in = a; b_in = b;
    z_in = z; n_in = n; c_in = c; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    // operands must have been captured; disturb them while the op runs
    in_valid = 1'b0;
    opcode = 4'($urandom); mask = 3'($urandom); shamt = 4'($urandom);
    a_in = 16'($urandom); b_in = 16'($urandom);
    z_in = ~z; n_in = ~n; c_in = ~c;
    lat = 1; rdy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("ready_low_in_flight", {63'd0, rdy_bad}, 64'd0);
    chk("a_out", {48'd0, a_out}, e.a);
    chk("b_out", {48'd0, b_out}, e.b);
    chk("flags_znc", {61'd0, z_out, n_out, c_out}, {61'd0, e.z, e.n, e.c});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("held_stable", {27'd0, in_ready, out_valid, z_out, n_out, c_out, b_out, a_out},
          {27'd0, 1'b0, 1'b1, e.z, e.n, e.c, e.b[15:0], e.a[15:0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  // single-cycle ops on the 32-bit instance; called at a negedge
  task automatic run32(input logic [3:0] op, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic z, input logic n, input logic c);
    res_t e;
    e = model(32, op, m, 0, {32'd0, a}, {32'd0, b}, z, n, c);
    chk("w_ready_before_req", {63'd0, w_in_ready}, 64'd1);
    w_opcode = op; w_mask = m; w_shamt = 5'd0; w_a_in = a; w_b_in = b;
    w_z_in = z; w_n_in = n; w_c_in = c; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("w_out_valid", {63'd0, w_out_valid}, 64'd1);
    chk("w_a_out", {32'd0, w_a_out}, e.a);
    chk("w_b_out", {32'd0, w_b_out}, e.b);
    chk("w_flags_znc", {61'd0, w_z_out, w_n_out, w_c_out}, {61'd0, e.z, e.n, e.c});
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  initial begin
    bit   seen;
    logic [3:0] op;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; opcode = '0; mask = '0; shamt = '0;
    a_in = '0; b_in = '0; z_in = 1'b0; n_in = 1'b0; c_in = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_opcode = '0; w_mask = '0; w_shamt = '0;
    w_a_in = '0; w_b_in = '0; w_z_in = 1'b0; w_n_in = 1'b0; w_c_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {28'd0, in_ready, out_valid, z_out, n_out, c_out, b_out, a_out},
        {28'd0, 1'b1, 1'b0, 35'd0});

    // directed corner cases
    run16(4'h4, 3'b000, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);   // ADD wrap
    run16(4'h5, 3'b000, 4'd0, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1);   // SUB borrow
    run16(4'hC, 3'b000, 4'd0, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 0);   // CMP
    run16(4'h9, 3'b000, 4'd2, 16'h8003, 16'h5555, 1'b1, 1'b0, 1'b0, 0);   // SHR by 2
    run16(4'h9, 3'b000, 4'd0, 16'h8003, 16'h5555, 1'b0, 1'b1, 1'b1, 0);   // SHR by 0
    run16(4'h9, 3'b000, 4'd15, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 0);  // SHR max
    run16(4'hB, 3'b000, 4'd0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 5);   // EXCH stalled
    run16(4'hD, 3'b101, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 0);   // SET
    run16(4'hE, 3'b011, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 0);   // CLR
    run16(4'h0, 3'b111, 4'd3, 16'hBEEF, 16'hCAFE, 1'b1, 1'b0, 1'b1, 0);   // PASS

    // reset part-way through a long shift: no result may appear
    wait_ready16();
    opcode = 4'h9; shamt = 4'd7; a_in = 16'hF0F0; b_in = 16'h1111; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_shift", {28'd0, in_ready, out_valid, z_out, n_out, c_out, b_out, a_out},
        {28'd0, 1'b1, 1'b0, 35'd0});
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("no_result_after_abort", {63'd0, seen}, 64'd0);

    // reset together with the result handshake, then together with an accept
    opcode = 4'h6; a_in = 16'h00F0; b_in = 16'h0F00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rst_in_done", {28'd0, in_ready, out_valid, z_out, n_out, c_out, b_out, a_out},
        {28'd0, 1'b1, 1'b0, 35'd0});
    in_valid = 1'b1;   // rst still high: this request must be dropped
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_beats_accept", {62'd0, in_ready, out_valid}, 64'd2);

    // random operations
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom);
      run16(op, 3'($urandom), 4'($urandom_range(0, 15)),
            (i % 10 == 0) ? 16'hFFFF : 16'($urandom), (i % 7 == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    // 32-bit instance
    run32(4'h4, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run32(4'hD, 3'b101, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run32(4'h5, 3'b000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom);
      if (op == 4'h9) op = 4'h8;
      run32(op, 3'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal range 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH): width of shift-amount field.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1: operation request present.
REQ-006 in_ready  output  1: block can accept a request.
REQ-007 opcode  input  4: operation select, encoding per REQ-016.
REQ-008 mask  input  3: flag mask for SET/CLR; bit2=Z, bit1=N, bit0=C.
REQ-009 shamt  input  SHW: SHR shift count.
REQ-010 a_in, b_in  input  WIDTH each: operands A and B.
REQ-011 z_in, n_in, c_in  input  1 each: current status flags.
REQ-012 out_valid  output  1: result present.
REQ-013 out_ready  input  1: consumer accepts result.
REQ-014 a_out, b_out  output  WIDTH each: result registers A and B.
REQ-015 z_out, n_out, c_out  output  1 each: resulting flags.

Function
REQ-016 Opcodes: 0100 ADD, 0101 SUB, 0110 OR, 0111 AND, 1000 XOR, 1001 SHR, 1010 MOV, 1011 EXCH, 1100 CMP, 1101 SET, 1110 CLR; all others PASS.
REQ-017 States IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-018 Accept = in_valid & in_ready; all inputs sampled on the accept edge only, and later input changes have no effect on the operation in flight.
REQ-019 Non-SHR op, or SHR with shamt=0: IDLE -> DONE on the accept edge; out_valid asserts the next cycle, i.e. latency 1.
REQ-020 SHR with shamt=k>0: IDLE -> SHIFT; one logical right shift per cycle, zero fill at MSB; SHIFT -> DONE after k shift cycles; out_valid asserts k+1 cycles after accept.
REQ-021 DONE: outputs held stable while out_ready=0; DONE -> IDLE on out_valid & out_ready.
REQ-022 No back-to-back acceptance: a new request is accepted no earlier than the cycle after the result handshake.
REQ-023 Defaults, unless overridden below: a_out=a_in, b_out=b_in, flags = flag inputs.
REQ-024 ADD: a_out = (a_in+b_in) mod 2^WIDTH; c_out = carry out of bit WIDTH-1.
REQ-025 SUB: a_out = (a_in-b_in) mod 2^WIDTH; c_out = 1 iff a_in < b_in unsigned (borrow).
REQ-026 OR/AND/XOR: a_out = bitwise result; c_out = c_in.
REQ-027 For ADD, SUB, OR, AND, XOR and CMP: z_out = (arith result == 0); n_out = result[WIDTH-1].
REQ-028 CMP: flags computed exactly as SUB; a_out = a_in (difference discarded).
REQ-029 SHR: a_out = a_in >> k; c_out = last bit shifted out (a_in[k-1]); z_out, n_out unchanged; shamt=0 leaves c_out = c_in.
REQ-030 MOV: b_out = a_in; flags unchanged.
REQ-031 EXCH: a_out = b_in, b_out = a_in; flags unchanged.
REQ-032 SET: each flag whose mask bit is 1 forced to 1, others pass. CLR: masked flags forced to 0, others pass.
REQ-033 PASS: all outputs equal the sampled inputs.

Reset
REQ-034 rst=1 at a clock edge: state -> IDLE; out_valid=0; a_out=b_out=0; z_out=n_out=c_out=0; in_ready=1 on the following cycle.
REQ-035 Reset during SHIFT or DONE aborts the operation; no out_valid pulse is produced for it.
REQ-036 rst dominates a simultaneous accept or result handshake.

Verification
REQ-037 WIDTH=16, ADD a=FFFF b=0001 -> after 1 cycle a_out=0000, Z=1, N=0, C=1.
REQ-038 SUB a=0003 b=0005 -> a_out=FFFE, Z=0, N=1, C=1; CMP with the same operands -> a_out=0003, same flags.
REQ-039 SHR a=8003 shamt=2 -> out_valid 3 cycles after accept, a_out=2000, C=1, Z/N = inputs; in_ready=0 throughout.
REQ-040 EXCH a=1234 b=ABCD with out_ready=0 for 5 cycles -> a_out=ABCD, b_out=1234, held stable; in_ready=1 the cycle after out_ready rises.
REQ-041 SHR shamt=7, rst asserted on cycle 3 -> next cycle out_valid=0, all outputs 0, in_ready=1; no result emitted.
REQ-042 WIDTH=32: ADD 7FFFFFFF+1 -> a_out=80000000, N=1, C=0; SET mask=101 with flags 000 -> Z=1, N=0, C=1.
